// File: rtl/dmem_line_if.sv
// Line-refill/write-back bus between the data cache (master) and its backing memory (slave).
interface dmem_line_if;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned LINE_W = 256;

  logic              enable_i;
  logic              write_i;
  logic [ADDR_W-1:0] addr_i;
  logic [LINE_W-1:0] data_i;
  logic              ack_o;
  logic [LINE_W-1:0] data_o;

  modport master (output enable_i, write_i, addr_i, data_i, input ack_o, data_o);
  modport slave  (input enable_i, write_i, addr_i, data_i, output ack_o, data_o);
endinterface

// File: rtl/dmem_line_responder.sv
// Fixed-latency 256-bit line memory answering the data cache's enable/ack protocol.
// Optional read/write transaction counters are enabled by defining DMEM_STATS_EN.
module dmem_line_responder #(
  parameter int unsigned LATENCY     = 10,
  parameter int unsigned DEPTH_LINES = 512,
  parameter int unsigned IDX_W       = 9
) (
  input  logic        clk_i,
  input  logic        rst_i,
  dmem_line_if.slave  bus
`ifdef DMEM_STATS_EN
  ,
  output logic [31:0] rd_cnt_o,
  output logic [31:0] wr_cnt_o
`endif
);
  localparam int unsigned CNT_W  = 8;
  localparam int unsigned LINE_W = 256;

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, ACK = 2'd2} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               wr_q, wr_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [LINE_W-1:0]  wdata_q, wdata_d;
  logic               ack_q, ack_d;
  logic [LINE_W-1:0]  rdata_q, rdata_d;
  logic               mem_we;
`ifdef DMEM_STATS_EN
  logic [31:0]        rd_cnt_q, rd_cnt_d;
  logic [31:0]        wr_cnt_q, wr_cnt_d;
`endif

  logic [LINE_W-1:0]  mem [DEPTH_LINES];

  // Address bits outside the line index alias and are deliberately dropped.
  logic unused_addr;
  assign unused_addr = ^{bus.addr_i[31:IDX_W+5], bus.addr_i[4:0]};

  // State and datapath registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      wr_q     <= 1'b0;
      idx_q    <= '0;
      wdata_q  <= '0;
      ack_q    <= 1'b0;
      rdata_q  <= '0;
`ifdef DMEM_STATS_EN
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wr_q     <= wr_d;
      idx_q    <= idx_d;
      wdata_q  <= wdata_d;
      ack_q    <= ack_d;
      rdata_q  <= rdata_d;
`ifdef DMEM_STATS_EN
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
`endif
    end
  end

  // Next-state logic; dropping enable in WAIT abandons the request.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (bus.enable_i) state_d = WAIT;
      WAIT: begin
        if (!bus.enable_i)      state_d = IDLE;
        else if (cnt_q == '0)   state_d = ACK;
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Capture, latency countdown and commit on the edge entering ACK.
  always_comb begin
    cnt_d    = cnt_q;
    wr_d     = wr_q;
    idx_d    = idx_q;
    wdata_d  = wdata_q;
    ack_d    = 1'b0;
    rdata_d  = rdata_q;
    mem_we   = 1'b0;
`ifdef DMEM_STATS_EN
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (bus.enable_i) begin
          wr_d    = bus.write_i;
          idx_d   = bus.addr_i[IDX_W+4:5];
          wdata_d = bus.data_i;
          cnt_d   = CNT_W'(LATENCY - 1);
        end
      end
      WAIT: begin
        if (bus.enable_i) begin
          if (cnt_q == '0) begin
            ack_d = 1'b1;
            if (wr_q) begin
              mem_we = 1'b1;
`ifdef DMEM_STATS_EN
              wr_cnt_d = wr_cnt_q + 32'd1;
`endif
            end else begin
              rdata_d = mem[idx_q];
`ifdef DMEM_STATS_EN
              rd_cnt_d = rd_cnt_q + 32'd1;
`endif
            end
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
      default: ;
    endcase
  end

  // Line array is not reset; writes are gated by the FSM, which is held in IDLE under reset.
  always_ff @(posedge clk_i) begin
    if (mem_we) mem[idx_q] <= wdata_q;
  end

  assign bus.ack_o  = ack_q;
  assign bus.data_o = rdata_q;
`ifdef DMEM_STATS_EN
  assign rd_cnt_o = rd_cnt_q;
  assign wr_cnt_o = wr_cnt_q;
`endif
endmodule

// File: tb/tb_dmem_line_responder.sv
// Directed bench for dmem_line_responder: cycle-level transaction model plus literal spot checks.
module tb_dmem_line_responder;
  localparam int unsigned LAT   = 10;
  localparam int unsigned DEPTH = 512;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dmem_line_if bus();
`ifdef DMEM_STATS_EN
  logic [31:0] rd_cnt, wr_cnt;
`endif

  dmem_line_responder #(.LATENCY(LAT), .DEPTH_LINES(DEPTH), .IDX_W(9)) dut (
    .clk_i(clk),
    .rst_i(rst_n),
    .bus(bus)
`ifdef DMEM_STATS_EN
    ,
    .rd_cnt_o(rd_cnt),
    .wr_cnt_o(wr_cnt)
`endif
  );

  typedef struct {
    int unsigned  cyc;
    bit           rd;
    logic [255:0] d;
  } exp_t;

  int unsigned  vec  = 0;
  int unsigned  fail = 0;
  int unsigned  cyc  = 0;
  exp_t         exp_q[$];
  logic [255:0] exp_data = '0;
  logic [255:0] mm [DEPTH];
  int unsigned  m_rd = 0;
  int unsigned  m_wr = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    vec++;
    if (act !== exp) begin
      fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Every cycle: ack must pulse exactly at accept_edge+LATENCY, data_o must hold the last read line.
  always @(negedge clk) begin
    bit exp_ack;
    if (rst_n) begin
      exp_ack = 1'b0;
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        exp_ack = 1'b1;
        if (exp_q[0].rd) begin
          exp_data = exp_q[0].d;
          m_rd++;
        end else begin
          m_wr++;
        end
        void'(exp_q.pop_front());
      end
      chk("ack_o", 256'(bus.ack_o), 256'(exp_ack));
      chk("data_o", bus.data_o, exp_data);
`ifdef DMEM_STATS_EN
      chk("rd_cnt_o", 256'(rd_cnt), 256'(m_rd));
      chk("wr_cnt_o", 256'(wr_cnt), 256'(m_wr));
`endif
    end
  end

  function automatic int unsigned idx_of(input logic [31:0] a);
    return (a >> 5) % DEPTH;
  endfunction

  // Called in an IDLE cycle at a negedge; returns in the following IDLE cycle.
  task automatic txn(input bit wr, input logic [31:0] a, input logic [255:0] d, input bit keep,
                     output int unsigned e0, output int unsigned ack_cyc);
    exp_t e;
    bit   seen;
    bus.enable_i = 1'b1;
    bus.write_i  = wr;
    bus.addr_i   = a;
    bus.data_i   = d;
    e0    = cyc + 1;
    e.cyc = e0 + LAT;
    e.rd  = !wr;
    e.d   = wr ? '0 : mm[idx_of(a)];
    if (wr) mm[idx_of(a)] = d;
    exp_q.push_back(e);
    seen    = 1'b0;
    ack_cyc = 0;
    for (int i = 0; i < int'(LAT) + 6; i++) begin
      @(negedge clk);
      if (bus.ack_o === 1'b1) begin
        seen    = 1'b1;
        ack_cyc = cyc;
        break;
      end
    end
    if (!seen) chk("ack_timeout", 256'(seen), 256'(1));
    if (!keep) bus.enable_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic abort_txn(input bit wr, input logic [31:0] a, input logic [255:0] d, input int n);
    bus.enable_i = 1'b1;
    bus.write_i  = wr;
    bus.addr_i   = a;
    bus.data_i   = d;
    repeat (n) @(negedge clk);
    bus.enable_i = 1'b0;
    @(negedge clk);
  endtask

  localparam logic [255:0] PAT_A = {8{32'hA5A5_0800}};
  localparam logic [255:0] PAT_B = {8{32'h1234_0020}};
  localparam logic [255:0] PAT_C = {8{32'hC0DE_4000}};
  localparam logic [255:0] PAT_D = {8{32'h0BAD_F00D}};
  localparam logic [255:0] BEEF  = {8{32'hDEADBEEF}};

  initial begin
    int unsigned e0, a1, a2;
    bus.enable_i = 1'b0;
    bus.write_i  = 1'b0;
    bus.addr_i   = '0;
    bus.data_i   = '0;
    #2;
    chk("reset_ack", 256'(bus.ack_o), 256'(0));
    chk("reset_data", bus.data_o, '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    txn(1'b1, 32'h0000_0800, PAT_A, 1'b0, e0, a1);
    txn(1'b1, 32'h0000_0020, PAT_B, 1'b0, e0, a1);

    // Write/read at LATENCY=10: ack visible in the cycle after accept edge + 10.
    txn(1'b1, 32'h0000_0040, BEEF, 1'b0, e0, a1);
    chk("wr_latency", 256'(a1 - e0), 256'(10));
    txn(1'b0, 32'h0000_0040, '0, 1'b0, e0, a1);
    chk("rd_latency", 256'(a1 - e0), 256'(10));
    chk("rd_beef", bus.data_o, BEEF);

    // Back-to-back with enable held across the ack: one IDLE turnaround cycle.
    txn(1'b1, 32'h0000_0400, PAT_D, 1'b1, e0, a1);
    txn(1'b0, 32'h0000_0800, '0, 1'b0, e0, a2);
    chk("b2b_spacing", 256'(a2 - a1), 256'(12));
    chk("b2b_data", bus.data_o, PAT_A);

    // Aborted write must leave the line intact.
    abort_txn(1'b1, 32'h0000_0020, 256'h1, 3);
    txn(1'b0, 32'h0000_0020, '0, 1'b0, e0, a1);
    chk("abort_data", bus.data_o, PAT_B);

    // Aliasing: 0x4000 and 0x0 share line index 0.
    txn(1'b1, 32'h0000_4000, PAT_C, 1'b0, e0, a1);
    txn(1'b0, 32'h0000_0000, '0, 1'b0, e0, a1);
    chk("alias_data", bus.data_o, PAT_C);

    // Stale enable after a read ack starts a read that aborts harmlessly.
    txn(1'b0, 32'h0000_0040, '0, 1'b1, e0, a1);
    @(negedge clk);
    bus.enable_i = 1'b0;
    @(negedge clk);
    txn(1'b0, 32'h0000_0400, '0, 1'b0, e0, a1);
    chk("after_stale", bus.data_o, PAT_D);

    // Reset during WAIT of a write: outputs clear at once, write dropped.
    bus.enable_i = 1'b1;
    bus.write_i  = 1'b1;
    bus.addr_i   = 32'h0000_0040;
    bus.data_i   = {8{32'h5555_AAAA}};
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_ack", 256'(bus.ack_o), 256'(0));
    chk("midrst_data", bus.data_o, '0);
    exp_q.delete();
    exp_data = '0;
    m_rd = 0;
    m_wr = 0;
    @(negedge clk);
    bus.enable_i = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);

    txn(1'b0, 32'h0000_0040, '0, 1'b0, e0, a1);
    chk("midrst_line", bus.data_o, BEEF);
    txn(1'b1, 32'h0000_0020, PAT_C, 1'b0, e0, a1);
    txn(1'b0, 32'h0000_0020, '0, 1'b0, e0, a1);
    chk("final_rd", bus.data_o, PAT_C);
    abort_txn(1'b0, 32'h0000_0800, '0, 2);
`ifdef DMEM_STATS_EN
    chk("stats_rd", 256'(rd_cnt), 256'(2));
    chk("stats_wr", 256'(wr_cnt), 256'(1));
`endif
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vec, fail);
    $finish;
  end
endmodule
